// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and types for the VGA raster generator and output stage.
package vga_timing_pkg;
    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int unsigned DEF_H_VISIBLE  = 640;
    localparam int unsigned DEF_H_FRONT    = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BACK     = 48;
    localparam int unsigned DEF_V_VISIBLE  = 480;
    localparam int unsigned DEF_V_FRONT    = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BACK     = 33;
    localparam int unsigned DEF_RENDER_LAT = 2;
    localparam logic        DEF_SYNC_POL   = 1'b0;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vga_ctl_t;

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction
endpackage

// File: rtl/vga_timing_if.sv
// Pixel-domain link between the raster generator, the text renderer and the pins.
interface vga_timing_if;
    import vga_timing_pkg::*;

    coord_t     x_coord;
    coord_t     y_coord;
    logic       frame_start;
    logic [2:0] h_dat;
    logic [2:0] vga_rgb;
    logic       h_sync;
    logic       v_sync;

    modport master (
        output x_coord, y_coord, frame_start, vga_rgb, h_sync, v_sync,
        input  h_dat
    );

    modport slave (
        input  x_coord, y_coord, frame_start, vga_rgb, h_sync, v_sync,
        output h_dat
    );
endinterface

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register with synchronous clear; depth 0 is a plain wire.
module vga_pipe_delay #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = clk ^ clr_i;
            assign q_o = d_i;
        end else begin : g_sr
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (clr_i) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_timing.sv
// Raster counters, coordinate outputs, sync/blank delay line and the pin register.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter int unsigned RENDER_LAT = DEF_RENDER_LAT,
    parameter logic        SYNC_POL   = DEF_SYNC_POL
) (
    input  logic         vga_clk,
    input  logic         reset,
    vga_timing_if.master vif
);
    localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t     h_cnt_q, h_cnt_d;
    coord_t     v_cnt_q, v_cnt_d;
    coord_t     x_coord_q, y_coord_q;
    logic       frame_start_q;
    logic       hold;
    vga_ctl_t   ctl_raw, ctl_dly;
    logic [2:0] rgb_q;
    logic       hs_q, vs_q;

    // (0,0) without frame_start only occurs straight out of reset: hold there one
    // cycle so the first free-running cycle presents (0,0) with frame_start high.
    always_comb begin
        hold    = (h_cnt_q == '0) && (v_cnt_q == '0) && !frame_start_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!hold) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + coord_t'(1);
            end else begin
                h_cnt_d = h_cnt_q + coord_t'(1);
            end
        end
        ctl_raw    = '0;
        ctl_raw.de = !hold && (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        ctl_raw.hs = !hold && in_window(h_cnt_q, HS_START, HS_END);
        ctl_raw.vs = !hold && in_window(v_cnt_q, VS_START, VS_END);
    end

    vga_pipe_delay #(
        .DEPTH (RENDER_LAT),
        .WIDTH ($bits(vga_ctl_t))
    ) u_delay (
        .clk   (vga_clk),
        .clr_i (reset),
        .d_i   (ctl_raw),
        .q_o   (ctl_dly)
    );

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_coord_q     <= '0;
            y_coord_q     <= '0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_coord_q     <= (h_cnt_d < H_VIS_C) ? h_cnt_d : '0;
            y_coord_q     <= (v_cnt_d < V_VIS_C) ? v_cnt_d : '0;
            frame_start_q <= (h_cnt_d == '0) && (v_cnt_d == '0);
            rgb_q         <= ctl_dly.de ? vif.h_dat : 3'b000;
            hs_q          <= ctl_dly.hs ? SYNC_POL : ~SYNC_POL;
            vs_q          <= ctl_dly.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign vif.x_coord     = x_coord_q;
    assign vif.y_coord     = y_coord_q;
    assign vif.frame_start = frame_start_q;
    assign vif.vga_rgb     = rgb_q;
    assign vif.h_sync      = hs_q;
    assign vif.v_sync      = vs_q;
endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default 640x480 build, a tiny-raster build and a zero-latency build.
module tb_vga_timing;
    import vga_timing_pkg::*;

    logic       clk = 1'b0;
    logic       rst_d, rst_s, rst_z;
    logic [2:0] dat_d, dat_s;
    int         cyc = 0;
    int         rel_d = 0, rel_s = 0, rel_z = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_if if_d();
    vga_timing_if if_s();
    vga_timing_if if_z();

    assign if_d.h_dat = dat_d;
    assign if_s.h_dat = dat_s;
    assign if_z.h_dat = if_z.x_coord[2:0];

    vga_timing u_dflt (
        .vga_clk (clk),
        .reset   (rst_d),
        .vif     (if_d)
    );

    vga_timing #(
        .H_VISIBLE  (16),
        .H_FRONT    (2),
        .H_SYNC     (3),
        .H_BACK     (3),
        .V_VISIBLE  (6),
        .V_FRONT    (1),
        .V_SYNC     (2),
        .V_BACK     (1),
        .RENDER_LAT (3)
    ) u_small (
        .vga_clk (clk),
        .reset   (rst_s),
        .vif     (if_s)
    );

    vga_timing #(
        .RENDER_LAT (0)
    ) u_zero (
        .vga_clk (clk),
        .reset   (rst_z),
        .vif     (if_z)
    );

    task automatic test_reset();
        rst_d = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (if_d.vga_rgb !== 3'h0) begin failures++; $display("FAIL reset_rgb actual=%h required=0", if_d.vga_rgb); end
        checks++; if (if_d.h_sync !== 1'b1) begin failures++; $display("FAIL reset_hsync actual=%b required=1", if_d.h_sync); end
        checks++; if (if_d.v_sync !== 1'b1) begin failures++; $display("FAIL reset_vsync actual=%b required=1", if_d.v_sync); end
        checks++; if (if_d.frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs actual=%b required=0", if_d.frame_start); end
        rst_d = 1'b0;
        @(negedge clk);
        rel_d = cyc;
        checks++; if (if_d.frame_start !== 1'b1) begin failures++; $display("FAIL release_fs actual=%b required=1", if_d.frame_start); end
        checks++; if (if_d.x_coord !== 10'd0) begin failures++; $display("FAIL release_x actual=%0d required=0", if_d.x_coord); end
        checks++; if (if_d.y_coord !== 10'd0) begin failures++; $display("FAIL release_y actual=%0d required=0", if_d.y_coord); end
        @(negedge clk);
        checks++; if (if_d.frame_start !== 1'b0) begin failures++; $display("FAIL fs_one_cycle actual=%b required=0", if_d.frame_start); end
        checks++; if (if_d.x_coord !== 10'd1) begin failures++; $display("FAIL x_step actual=%0d required=1", if_d.x_coord); end
    endtask

    task automatic test_hsync();
        int   fall0 = -1;
        int   fall1 = -1;
        int   low_w = 0;
        int   vs_low = 0;
        logic prev = 1'b1;
        for (int r = 2; r <= 1500; r++) begin
            @(negedge clk);
            if (prev && !if_d.h_sync) begin
                if (fall0 < 0) fall0 = r;
                else if (fall1 < 0) fall1 = r;
            end
            if (!if_d.h_sync && fall1 < 0) low_w++;
            if (!if_d.v_sync) vs_low++;
            prev = if_d.h_sync;
            if (r == 800) begin
                checks++; if (if_d.y_coord !== 10'd1) begin failures++; $display("FAIL line1_y actual=%0d required=1", if_d.y_coord); end
                checks++; if (if_d.x_coord !== 10'd0) begin failures++; $display("FAIL line1_x actual=%0d required=0", if_d.x_coord); end
            end
            if (r == 1439) begin
                checks++; if (if_d.x_coord !== 10'd639) begin failures++; $display("FAIL last_vis_x actual=%0d required=639", if_d.x_coord); end
            end
            if (r == 1440) begin
                checks++; if (if_d.x_coord !== 10'd0) begin failures++; $display("FAIL blank_x actual=%0d required=0", if_d.x_coord); end
            end
        end
        checks++; if (fall0 != 659) begin failures++; $display("FAIL hs_first_fall actual=%0d required=659", fall0); end
        checks++; if (fall1 != 1459) begin failures++; $display("FAIL hs_second_fall actual=%0d required=1459", fall1); end
        checks++; if (low_w != 96) begin failures++; $display("FAIL hs_width actual=%0d required=96", low_w); end
        checks++; if (vs_low != 0) begin failures++; $display("FAIL vs_idle_lows actual=%0d required=0", vs_low); end
    endtask

    task automatic test_rgb_blank();
        int on_cnt = 0;
        int off_cnt = 0;
        for (int r = 1501; r <= 2410; r++) begin
            @(negedge clk);
            if (r >= 1603 && r < 2403) begin
                if (if_d.vga_rgb === 3'h3) on_cnt++;
                if (if_d.vga_rgb === 3'h0) off_cnt++;
            end
            if (r == 1602) begin
                checks++; if (if_d.vga_rgb !== 3'h0) begin failures++; $display("FAIL rgb_pre_line actual=%h required=0", if_d.vga_rgb); end
            end
            if (r == 1603) begin
                checks++; if (if_d.vga_rgb !== 3'h3) begin failures++; $display("FAIL rgb_first_pix actual=%h required=3", if_d.vga_rgb); end
            end
            if (r == 2242) begin
                checks++; if (if_d.vga_rgb !== 3'h3) begin failures++; $display("FAIL rgb_last_pix actual=%h required=3", if_d.vga_rgb); end
            end
            if (r == 2243) begin
                checks++; if (if_d.vga_rgb !== 3'h0) begin failures++; $display("FAIL rgb_first_blank actual=%h required=0", if_d.vga_rgb); end
            end
        end
        checks++; if (on_cnt != 640) begin failures++; $display("FAIL rgb_on_count actual=%0d required=640", on_cnt); end
        checks++; if (off_cnt != 160) begin failures++; $display("FAIL rgb_off_count actual=%0d required=160", off_cnt); end
    endtask

    // Tiny raster: H total 24 (sync 18..20), V total 10 (sync lines 7..8), latency 3+1.
    task automatic test_frame_small();
        int   vs_fall = -1;
        int   vs_low = 0;
        int   fs_extra = 0;
        int   cnt5 = 0;
        int   blank_bad = 0;
        logic prev_vs = 1'b1;
        dat_s = 3'h5;
        @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        rel_s = cyc;
        checks++; if (if_s.frame_start !== 1'b1) begin failures++; $display("FAIL small_fs0 actual=%b required=1", if_s.frame_start); end
        for (int r = 1; r <= 260; r++) begin
            @(negedge clk);
            if (prev_vs && !if_s.v_sync && vs_fall < 0) vs_fall = r;
            if (!if_s.v_sync && r < 240) vs_low++;
            prev_vs = if_s.v_sync;
            if (r < 240 && if_s.frame_start) fs_extra++;
            if (r >= 4 && r < 28 && if_s.vga_rgb === 3'h5) cnt5++;
            if (r >= 148 && r < 244 && if_s.vga_rgb !== 3'h0) blank_bad++;
            if (r == 123) begin
                checks++; if (if_s.x_coord !== 10'd3) begin failures++; $display("FAIL small_x actual=%0d required=3", if_s.x_coord); end
                checks++; if (if_s.y_coord !== 10'd5) begin failures++; $display("FAIL small_y actual=%0d required=5", if_s.y_coord); end
            end
            if (r == 135) begin
                checks++; if (if_s.x_coord !== 10'd15) begin failures++; $display("FAIL small_x_edge actual=%0d required=15", if_s.x_coord); end
            end
            if (r == 144) begin
                checks++; if (if_s.y_coord !== 10'd0) begin failures++; $display("FAIL small_y_blank actual=%0d required=0", if_s.y_coord); end
            end
            if (r == 240) begin
                checks++; if (if_s.frame_start !== 1'b1) begin failures++; $display("FAIL small_fs_wrap actual=%b required=1", if_s.frame_start); end
                checks++; if (if_s.x_coord !== 10'd0 || if_s.y_coord !== 10'd0) begin failures++; $display("FAIL small_wrap_xy actual=%0d,%0d required=0,0", if_s.x_coord, if_s.y_coord); end
            end
            if (r == 241) begin
                checks++; if (if_s.x_coord !== 10'd1) begin failures++; $display("FAIL small_after_wrap_x actual=%0d required=1", if_s.x_coord); end
            end
        end
        checks++; if (vs_fall != 172) begin failures++; $display("FAIL small_vs_fall actual=%0d required=172", vs_fall); end
        checks++; if (vs_low != 48) begin failures++; $display("FAIL small_vs_width actual=%0d required=48", vs_low); end
        checks++; if (fs_extra != 0) begin failures++; $display("FAIL small_fs_extra actual=%0d required=0", fs_extra); end
        checks++; if (cnt5 != 16) begin failures++; $display("FAIL small_line_pixels actual=%0d required=16", cnt5); end
        checks++; if (blank_bad != 0) begin failures++; $display("FAIL small_vblank_pixels actual=%0d required=0", blank_bad); end
    endtask

    // Reset lands while the counter sits at (19,4), with sync already queued in the delay line.
    task automatic test_reset_midframe();
        int   hs_early = 0;
        for (int r = 261; r <= 355; r++) @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        checks++; if (if_s.x_coord !== 10'd0 || if_s.y_coord !== 10'd0) begin failures++; $display("FAIL mid_reset_xy actual=%0d,%0d required=0,0", if_s.x_coord, if_s.y_coord); end
        checks++; if (if_s.h_sync !== 1'b1) begin failures++; $display("FAIL mid_reset_hsync actual=%b required=1", if_s.h_sync); end
        rst_s = 1'b0;
        @(negedge clk);
        checks++; if (if_s.frame_start !== 1'b1) begin failures++; $display("FAIL mid_release_fs actual=%b required=1", if_s.frame_start); end
        for (int r = 1; r <= 30; r++) begin
            @(negedge clk);
            if (r < 22 && if_s.h_sync !== 1'b1) hs_early++;
            if (r == 22) begin
                checks++; if (if_s.h_sync !== 1'b0) begin failures++; $display("FAIL mid_hs_fall actual=%b required=0", if_s.h_sync); end
            end
        end
        checks++; if (hs_early != 0) begin failures++; $display("FAIL mid_partial_sync actual=%0d required=0", hs_early); end
    endtask

    task automatic test_zero_latency();
        int   fall = -1;
        logic prev = 1'b1;
        @(negedge clk);
        rst_z = 1'b0;
        @(negedge clk);
        rel_z = cyc;
        checks++; if (if_z.frame_start !== 1'b1) begin failures++; $display("FAIL zero_fs0 actual=%b required=1", if_z.frame_start); end
        for (int r = 1; r <= 700; r++) begin
            logic [9:0] pix;
            @(negedge clk);
            pix = 10'(r - 1);
            if (prev && !if_z.h_sync && fall < 0) fall = r;
            prev = if_z.h_sync;
            if (r <= 12 || r == 640) begin
                checks++; if (if_z.vga_rgb !== pix[2:0]) begin failures++; $display("FAIL zero_rgb_r%0d actual=%h required=%h", r, if_z.vga_rgb, pix[2:0]); end
            end
            if (r == 641) begin
                checks++; if (if_z.vga_rgb !== 3'h0) begin failures++; $display("FAIL zero_rgb_blank actual=%h required=0", if_z.vga_rgb); end
            end
        end
        checks++; if (fall != 657) begin failures++; $display("FAIL zero_hs_fall actual=%0d required=657", fall); end
    endtask

    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
        rst_z = 1'b1;
        dat_d = 3'h3;
        dat_s = 3'h0;
        test_reset();
        test_hsync();
        test_rgb_blank();
        test_frame_small();
        test_reset_midframe();
        test_zero_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator and output stage for the VGA text path, running in the pixel clock domain.
- Produces the x_coord/y_coord pixel coordinates consumed by the text renderer.
- Takes the renderer's registered h_dat colour back in, blanks it outside the visible area, and drives the pins.
- Delays h_sync/v_sync so they stay aligned with the renderer's pipeline latency.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- RENDER_LAT, 2, clock cycles from x_coord/y_coord to the corresponding h_dat (range 0..7)
- SYNC_POL, 1'b0, active level of h_sync/v_sync

Ports:
- vga_clk  in  1  pixel clock (25.175 MHz nominal)
- reset  in  1  synchronous, active-high reset
- x_coord  out  10  pixel column; equals h_cnt while h_cnt < H_VISIBLE, else 0
- y_coord  out  10  pixel row; equals v_cnt while v_cnt < V_VISIBLE, else 0
- frame_start  out  1  one-cycle pulse when h_cnt==0 && v_cnt==0
- h_dat  in  3  renderer colour, valid RENDER_LAT cycles after the matching coordinates
- vga_rgb  out  3  blanked colour to the pins
- h_sync  out  1  horizontal sync, aligned with vga_rgb
- v_sync  out  1  vertical sync, aligned with vga_rgb

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- h_cnt: 10-bit register, 0..H_TOTAL-1. Increments every cycle and wraps to 0.
- v_cnt: 10-bit register, 0..V_TOTAL-1. Increments only on the cycle h_cnt wraps. Wraps to 0 when that cycle is also v_cnt==V_TOTAL-1.
- x_coord, y_coord, frame_start: registered outputs reflecting the current h_cnt/v_cnt. No extra delay relative to the counters.
- Raw terms, computed from the counters each cycle:
  - de_raw = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
  - hs_raw is active for H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - vs_raw is active for V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491), for whole lines
- Delay: de_raw, hs_raw and vs_raw pass through a RENDER_LAT-stage shift register. The output of that shift register is aligned with h_dat.
- Output register, one further stage:
  - vga_rgb <= de_d ? h_dat : 3'b000
  - h_sync <= hs_d ? SYNC_POL : ~SYNC_POL
  - v_sync likewise from vs_d
- Total latency from a counter value to its pin-level sync/rgb is RENDER_LAT+1 cycles.
- Reset (synchronous, takes effect on the clock edge where reset is high):
  - h_cnt=0, v_cnt=0, x_coord=0, y_coord=0, frame_start=0
  - all delay stages inactive: de=0, syncs inactive
  - vga_rgb=0, h_sync=~SYNC_POL, v_sync=~SYNC_POL
- Cycle after reset release: counters are at (0,0) and frame_start=1.
- Reset mid-frame: the raster restarts at (0,0) and no partial sync pulse survives in the delay line.
- RENDER_LAT=0: the delay line degenerates to a wire. Sync and rgb then see only the output register.
- Corner wraps: at h_cnt=799, v_cnt=524 both counters return to 0 on the same edge.
- No other state and no handshake: the pipeline is free-running.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480@60 timing constants
  - a typedef for the 10-bit coordinate
  - a packed struct {de, hs, vs} used in the delay line
- One sub-module, vga_pipe_delay: a parameterised-depth (DEPTH, WIDTH) shift register with synchronous clear. It carries the struct through the RENDER_LAT stages.

Test Plan:
- Reset held 5 cycles, then released -> during reset vga_rgb=0 and h_sync=v_sync=1. First cycle after release: frame_start=1, x_coord=0, y_coord=0.
- Free run, defaults -> h_sync low for exactly 96 cycles; its first falling edge is 656+3=659 cycles after the frame_start cycle; period is 800 cycles.
- Free run -> v_sync low for 2×800=1600 cycles, starting at line 490 (+3-cycle offset); frame_start period is 420000 cycles.
- h_dat forced to 3'h3 continuously -> vga_rgb=3'h3 for exactly 640 consecutive cycles per visible line and 0 for 160. Every line from 480 to 524 is all zero.
- Reset pulsed for 1 cycle at h_cnt=700, v_cnt=300 (inside h_sync) -> next cycle counters are (0,0) and h_sync returns high. The next h_sync low is 659 cycles after release.
- RENDER_LAT=0 build -> h_sync falling edge occurs 657 cycles after frame_start; an h_dat change at a coordinate appears on vga_rgb 1 cycle later.
